// File: rtl/max7219_pkg.sv
// Shared constants for the MAX7219 receiver: frame geometry and register address map.
package max7219_pkg;

    localparam int WORD_BITS     = 16;
    localparam int DATAWIDTH_BUS = 8;

    localparam logic [3:0] ADDR_NOOP      = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
    localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
    localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
    localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
    localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
    localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
    localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
    localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
    localparam logic [3:0] ADDR_DECODE    = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY = 4'hA;
    localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
    localparam logic [3:0] ADDR_TEST      = 4'hF;

endpackage

// File: rtl/sc_spi_edge_sync.sv
// N-stage synchronizer for one SPI line with registered rise/fall pulses.
// level_o is the delayed copy, so it is time-aligned with the edge pulses.
module sc_spi_edge_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;
    logic              rise_q;
    logic              fall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RST_VAL}};
            dly_q  <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], sig_i};
            dly_q  <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~dly_q;
            fall_q <= ~sync_q[STAGES-1] & dly_q;
        end
    end

    assign level_o = dly_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/sc_max7219_receiver.sv
// MAX7219 serial receiver: deframes 16-bit words from DIN/CLK/NCS and mirrors
// the digit rows and control registers, with a registered row read port.
module sc_max7219_receiver
    import max7219_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int WORD_BITS     = max7219_pkg::WORD_BITS,
    parameter int DATAWIDTH_BUS = max7219_pkg::DATAWIDTH_BUS
) (
    input  logic                     SC_MAX7219RX_CLOCK_50,
    input  logic                     SC_MAX7219RX_RESET_InHigh,
    input  logic                     SC_MAX7219RX_din_In,
    input  logic                     SC_MAX7219RX_clk_In,
    input  logic                     SC_MAX7219RX_ncs_In,
    input  logic [2:0]               SC_MAX7219RX_rowAddr_InBUS,
    output logic [DATAWIDTH_BUS-1:0] SC_MAX7219RX_rowData_OutBUS,
    output logic [WORD_BITS-1:0]     SC_MAX7219RX_word_OutBUS,
    output logic                     SC_MAX7219RX_wordValid_Out,
    output logic                     SC_MAX7219RX_frameErr_Out,
    output logic [3:0]               SC_MAX7219RX_intensity_OutBUS,
    output logic [2:0]               SC_MAX7219RX_scanLimit_OutBUS,
    output logic [DATAWIDTH_BUS-1:0] SC_MAX7219RX_decodeMode_OutBUS,
    output logic                     SC_MAX7219RX_shutdown_Out,
    output logic                     SC_MAX7219RX_displayTest_Out
);

    localparam logic [4:0] CNT_MAX  = 5'd31;
    localparam logic [4:0] CNT_WORD = 5'(WORD_BITS);

    logic clk_i;
    logic rst_i;
    assign clk_i = SC_MAX7219RX_CLOCK_50;
    assign rst_i = SC_MAX7219RX_RESET_InHigh;

    logic din_lvl, din_rise_unused, din_fall_unused;
    logic sclk_lvl_unused, sclk_rise, sclk_fall_unused;
    logic ncs_lvl, ncs_rise, ncs_fall;

    sc_spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
        .clk_i(clk_i), .rst_i(rst_i), .sig_i(SC_MAX7219RX_din_In),
        .level_o(din_lvl), .rise_o(din_rise_unused), .fall_o(din_fall_unused)
    );

    sc_spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
        .clk_i(clk_i), .rst_i(rst_i), .sig_i(SC_MAX7219RX_clk_In),
        .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall_unused)
    );

    sc_spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk_i(clk_i), .rst_i(rst_i), .sig_i(SC_MAX7219RX_ncs_In),
        .level_o(ncs_lvl), .rise_o(ncs_rise), .fall_o(ncs_fall)
    );

    logic [WORD_BITS-1:0]     shift_q, shift_d;
    logic [4:0]               cnt_q, cnt_d;
    logic                     accept_d, discard_d;
    logic [3:0]               acc_addr;
    logic [DATAWIDTH_BUS-1:0] acc_data;

    logic [DATAWIDTH_BUS-1:0] rows_q [8];
    logic [DATAWIDTH_BUS-1:0] row_data_q;
    logic [WORD_BITS-1:0]     word_q;
    logic                     word_valid_q, frame_err_q;
    logic [3:0]               intensity_q;
    logic [2:0]               scan_limit_q;
    logic [DATAWIDTH_BUS-1:0] decode_mode_q;
    logic                     shutdown_q, display_test_q;

    // Frame close wins over a coincident clock edge: that last bit is dropped.
    always_comb begin
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        accept_d  = 1'b0;
        discard_d = 1'b0;
        if (ncs_rise) begin
            if (cnt_q >= CNT_WORD) accept_d = 1'b1;
            else                   discard_d = 1'b1;
            cnt_d = '0;
        end else if (ncs_fall) begin
            cnt_d = '0;
        end else if (sclk_rise && !ncs_lvl) begin
            shift_d = {shift_q[WORD_BITS-2:0], din_lvl};
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 5'd1;
        end
    end

    assign acc_addr = shift_q[11:8];
    assign acc_data = shift_q[DATAWIDTH_BUS-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q        <= '0;
            cnt_q          <= '0;
            word_q         <= '0;
            word_valid_q   <= 1'b0;
            frame_err_q    <= 1'b0;
            row_data_q     <= '0;
            intensity_q    <= '0;
            scan_limit_q   <= '0;
            decode_mode_q  <= '0;
            shutdown_q     <= 1'b1;
            display_test_q <= 1'b0;
            for (int i = 0; i < 8; i++) rows_q[i] <= '0;
        end else begin
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            word_valid_q <= accept_d;
            frame_err_q  <= discard_d;
            row_data_q   <= rows_q[SC_MAX7219RX_rowAddr_InBUS];
            if (accept_d) begin
                word_q <= shift_q;
                case (acc_addr)
                    ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3,
                    ADDR_DIGIT4, ADDR_DIGIT5, ADDR_DIGIT6, ADDR_DIGIT7:
                        rows_q[3'(acc_addr - ADDR_DIGIT0)] <= acc_data;
                    ADDR_DECODE:    decode_mode_q  <= acc_data;
                    ADDR_INTENSITY: intensity_q    <= acc_data[3:0];
                    ADDR_SCANLIMIT: scan_limit_q   <= acc_data[2:0];
                    ADDR_SHUTDOWN:  shutdown_q     <= ~acc_data[0];
                    ADDR_TEST:      display_test_q <= acc_data[0];
                    default: ;
                endcase
            end
        end
    end

    assign SC_MAX7219RX_rowData_OutBUS    = row_data_q;
    assign SC_MAX7219RX_word_OutBUS       = word_q;
    assign SC_MAX7219RX_wordValid_Out     = word_valid_q;
    assign SC_MAX7219RX_frameErr_Out      = frame_err_q;
    assign SC_MAX7219RX_intensity_OutBUS  = intensity_q;
    assign SC_MAX7219RX_scanLimit_OutBUS  = scan_limit_q;
    assign SC_MAX7219RX_decodeMode_OutBUS = decode_mode_q;
    assign SC_MAX7219RX_shutdown_Out      = shutdown_q;
    assign SC_MAX7219RX_displayTest_Out   = display_test_q;

endmodule
